// File: rtl/riscV_unrn_pkg.sv
// Shared core types: data-memory access kinds, machine timer addresses and reset constants.
package riscV_unrn_pkg;

    localparam logic [31:0] MTIME_MEM_ADDRESS_LOW     = 32'h0000_8000;
    localparam logic [31:0] MTIME_MEM_ADDRESS_HIGH    = 32'h0000_8004;
    localparam logic [31:0] MTIMECMP_MEM_ADDRESS_LOW  = 32'h0000_8008;
    localparam logic [31:0] MTIMECMP_MEM_ADDRESS_HIGH = 32'h0000_800C;

    localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

    // mcause value for the machine timer interrupt (interrupt bit set, code 7)
    localparam logic [31:0] M_TIMER_INT = 32'h8000_0007;

    typedef enum logic [3:0] {
        MEM_NOP = 4'd0,
        MEM_LB  = 4'd1,
        MEM_LH  = 4'd2,
        MEM_LW  = 4'd3,
        MEM_LBU = 4'd4,
        MEM_LHU = 4'd5,
        MEM_SB  = 4'd6,
        MEM_SH  = 4'd7,
        MEM_SW  = 4'd8
    } mem_inst_type_t;

    typedef enum logic [1:0] {
        MTIME_LOW     = 2'd0,
        MTIME_HIGH    = 2'd1,
        MTIMECMP_LOW  = 2'd2,
        MTIMECMP_HIGH = 2'd3
    } mtime_address_t;

    function automatic logic is_load(input mem_inst_type_t t);
        return t inside {MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU};
    endfunction

endpackage

// File: rtl/mtimer_prescaler.sv
// Divides clk down to one-cycle mtime tick pulses, one every PRESCALE cycles.
module mtimer_prescaler
    import riscV_unrn_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick_o
);

    localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // With PRESCALE=1 the counter is stuck at 0 and tick_o folds to a constant 1.
    assign tick_o = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d = tick_o ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mtimer_unit.sv
// Memory-mapped RISC-V machine timer: 64-bit mtime/mtimecmp as four 32-bit words,
// driving the registered machine timer interrupt level.
module mtimer_unit
    import riscV_unrn_pkg::*;
#(
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  mem_inst_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        hit_o,
    output logic [31:0] rdata_o,
    output logic        rvalid_o,
    output logic        err_o,
    output logic        mtip_o
);

    mem_inst_type_t inst;
    mtime_address_t sel;
    logic           addr_match;
    logic           tick;
    logic           do_load;
    logic           do_store;

    logic [63:0] mtime_q, mtime_d, mtime_inc;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic [31:0] rd_word;
    logic [31:0] rdata_q, rdata_d;
    logic        rvalid_q, rvalid_d;
    logic        err_q, err_d;
    logic        mtip_q, mtip_d;

    mtimer_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
        .clk   (clk),
        .rst_n (rst_n),
        .tick_o(tick)
    );

    assign inst = mem_inst_type_t'(mem_inst_i);

    always_comb begin
        addr_match = 1'b1;
        sel        = MTIME_LOW;
        case (addr_i)
            MTIME_MEM_ADDRESS_LOW:     sel = MTIME_LOW;
            MTIME_MEM_ADDRESS_HIGH:    sel = MTIME_HIGH;
            MTIMECMP_MEM_ADDRESS_LOW:  sel = MTIMECMP_LOW;
            MTIMECMP_MEM_ADDRESS_HIGH: sel = MTIMECMP_HIGH;
            default:                   addr_match = 1'b0;
        endcase
    end

    assign hit_o    = (inst != MEM_NOP) && addr_match;
    assign do_load  = hit_o && is_load(inst);
    assign do_store = hit_o && (inst == MEM_SW);
    assign mtime_inc = mtime_q + 64'd1;

    // A store to one mtime half in a tick cycle wins over the increment for that
    // half only; no carry ever crosses between a written and an incremented half.
    always_comb begin
        mtime_d    = tick ? mtime_inc : mtime_q;
        mtimecmp_d = mtimecmp_q;
        if (do_store) begin
            case (sel)
                MTIME_LOW:     mtime_d    = {mtime_q[63:32], wdata_i};
                MTIME_HIGH:    mtime_d    = {wdata_i, tick ? mtime_inc[31:0] : mtime_q[31:0]};
                MTIMECMP_LOW:  mtimecmp_d = {mtimecmp_q[63:32], wdata_i};
                MTIMECMP_HIGH: mtimecmp_d = {wdata_i, mtimecmp_q[31:0]};
                default:       mtimecmp_d = mtimecmp_q;
            endcase
        end
    end

    always_comb begin
        case (sel)
            MTIME_LOW:     rd_word = mtime_q[31:0];
            MTIME_HIGH:    rd_word = mtime_q[63:32];
            MTIMECMP_LOW:  rd_word = mtimecmp_q[31:0];
            MTIMECMP_HIGH: rd_word = mtimecmp_q[63:32];
            default:       rd_word = '0;
        endcase
        rdata_d  = do_load ? rd_word : rdata_q;
        rvalid_d = do_load;
        err_d    = hit_o && !is_load(inst) && (inst != MEM_SW);
        mtip_d   = (mtime_q >= mtimecmp_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mtime_q    <= '0;
            mtimecmp_q <= MTIMECMP_RESET;
            rdata_q    <= '0;
            rvalid_q   <= 1'b0;
            err_q      <= 1'b0;
            mtip_q     <= 1'b0;
        end else begin
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            rdata_q    <= rdata_d;
            rvalid_q   <= rvalid_d;
            err_q      <= err_d;
            mtip_q     <= mtip_d;
        end
    end

    assign rdata_o  = rdata_q;
    assign rvalid_o = rvalid_q;
    assign err_o    = err_q;
    assign mtip_o   = mtip_q;

endmodule

// File: tb/tb_mtimer_unit.sv
// Scoreboard bench for mtimer_unit: one instance with PRESCALE=1, one with PRESCALE=4.
module tb_mtimer_unit;
    import riscV_unrn_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, rst4_n;
    logic [3:0]  inst1, inst4;
    logic [31:0] addr1, addr4, wd1, wd4;
    logic        hit1, rvalid1, err1, mtip1;
    logic        hit4, rvalid4, err4, mtip4;
    logic [31:0] rdata1, rdata4;

    mtimer_unit #(.PRESCALE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .mem_inst_i(inst1), .addr_i(addr1), .wdata_i(wd1),
        .hit_o(hit1), .rdata_o(rdata1), .rvalid_o(rvalid1), .err_o(err1), .mtip_o(mtip1)
    );

    mtimer_unit #(.PRESCALE(4)) u_dut4 (
        .clk(clk), .rst_n(rst4_n), .mem_inst_i(inst4), .addr_i(addr4), .wdata_i(wd4),
        .hit_o(hit4), .rdata_o(rdata4), .rvalid_o(rvalid4), .err_o(err4), .mtip_o(mtip4)
    );

    typedef struct {
        logic        is_err;
        logic [31:0] data;
        string       name;
    } exp_t;

    exp_t q1[$];
    exp_t q4[$];
    exp_t m1, m4;
    int   checks = 0;
    int   errors = 0;
    int   p4_exp[7] = '{100, 100, 101, 101, 101, 101, 102};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic expect_resp(input int d, input logic is_err, input logic [31:0] data,
                               input string name);
        exp_t e;
        e.is_err = is_err;
        e.data   = data;
        e.name   = name;
        if (d == 1) q1.push_back(e);
        else        q4.push_back(e);
    endtask

    // Caller sits just after a rising edge; the access is sampled on the next one.
    task automatic acc(input int d, input mem_inst_type_t op, input logic [31:0] a,
                       input logic [31:0] wd, input logic exp_hit, input string name);
        if (d == 1) begin
            inst1 = op; addr1 = a; wd1 = wd;
        end else begin
            inst4 = op; addr4 = a; wd4 = wd;
        end
        @(negedge clk);
        check({name, "_hit"}, (d == 1) ? hit1 : hit4, exp_hit);
        @(posedge clk);
        #1;
        inst1 = MEM_NOP; addr1 = '0; wd1 = '0;
        inst4 = MEM_NOP; addr4 = '0; wd4 = '0;
    endtask

    task automatic ld(input int d, input mem_inst_type_t op, input logic [31:0] a,
                      input logic [31:0] exp, input string name);
        expect_resp(d, 1'b0, exp, name);
        acc(d, op, a, '0, 1'b1, name);
    endtask

    task automatic sw(input int d, input logic [31:0] a, input logic [31:0] wd, input string name);
        acc(d, MEM_SW, a, wd, 1'b1, name);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_mtip1(input logic exp, input string name);
        @(negedge clk);
        check(name, mtip1, exp);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rvalid1 || err1) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut1_spurious: rvalid=%b err=%b rdata=%h, required no response",
                         rvalid1, err1, rdata1);
            end else begin
                m1 = q1.pop_front();
                check({m1.name, "_kind"}, {62'd0, rvalid1, err1}, {62'd0, !m1.is_err, m1.is_err});
                if (!m1.is_err) check(m1.name, {32'd0, rdata1}, {32'd0, m1.data});
            end
        end
    end

    always @(negedge clk) begin
        if (rvalid4 || err4) begin
            if (q4.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut4_spurious: rvalid=%b err=%b rdata=%h, required no response",
                         rvalid4, err4, rdata4);
            end else begin
                m4 = q4.pop_front();
                check({m4.name, "_kind"}, {62'd0, rvalid4, err4}, {62'd0, !m4.is_err, m4.is_err});
                if (!m4.is_err) check(m4.name, {32'd0, rdata4}, {32'd0, m4.data});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; rst4_n = 1'b0;
        inst1 = MEM_NOP; addr1 = '0; wd1 = '0;
        inst4 = MEM_NOP; addr4 = '0; wd4 = '0;
        #12;
        check("rst_rdata1", rdata1, 0);
        check("rst_rvalid1", rvalid1, 0);
        check("rst_err1", err1, 0);
        check("rst_mtip1", mtip1, 0);
        check("rst_hit1", hit1, 0);
        check("rst_rdata4", rdata4, 0);
        check("rst_rvalid4", rvalid4, 0);
        check("rst_mtip4", mtip4, 0);

        // PRESCALE=1: mtime equals the number of edges since release.
        @(posedge clk); #1; rst_n = 1'b1;
        idle(10);
        ld(1, MEM_LW, MTIME_MEM_ADDRESS_LOW, 32'd10, "rst_mtime_lo");
        ld(1, MEM_LW, MTIMECMP_MEM_ADDRESS_LOW, 32'hFFFF_FFFF, "rst_cmp_lo");
        ld(1, MEM_LW, MTIMECMP_MEM_ADDRESS_HIGH, 32'hFFFF_FFFF, "rst_cmp_hi");
        ld(1, MEM_LW, MTIME_MEM_ADDRESS_HIGH, 32'd0, "rst_mtime_hi");

        // Write collision: low write in a tick cycle is not incremented, high untouched.
        sw(1, MTIME_MEM_ADDRESS_HIGH, 32'h0000_1234, "coll_sw_hi");
        sw(1, MTIME_MEM_ADDRESS_LOW, 32'd5, "coll_sw_lo");
        ld(1, MEM_LW, MTIME_MEM_ADDRESS_LOW, 32'd5, "coll_lo");
        ld(1, MEM_LW, MTIME_MEM_ADDRESS_HIGH, 32'h0000_1234, "coll_hi");

        // Low-to-high carry.
        sw(1, MTIME_MEM_ADDRESS_HIGH, 32'd0, "carry_sw_hi");
        sw(1, MTIME_MEM_ADDRESS_LOW, 32'hFFFF_FFFE, "carry_sw_lo");
        ld(1, MEM_LW, MTIME_MEM_ADDRESS_LOW, 32'hFFFF_FFFE, "carry_lo0");
        ld(1, MEM_LW, MTIME_MEM_ADDRESS_LOW, 32'hFFFF_FFFF, "carry_lo1");
        ld(1, MEM_LW, MTIME_MEM_ADDRESS_HIGH, 32'd1, "carry_hi");
        ld(1, MEM_LW, MTIME_MEM_ADDRESS_LOW, 32'd1, "carry_lo2");

        // 64-bit wrap; mtime = all-ones briefly meets the reset mtimecmp.
        sw(1, MTIME_MEM_ADDRESS_HIGH, 32'hFFFF_FFFF, "wrap_sw_hi");
        sw(1, MTIME_MEM_ADDRESS_LOW, 32'hFFFF_FFFE, "wrap_sw_lo");
        chk_mtip1(1'b0, "wrap_mtip_a");
        chk_mtip1(1'b0, "wrap_mtip_b");
        chk_mtip1(1'b1, "wrap_mtip_max");
        chk_mtip1(1'b0, "wrap_mtip_zero");
        ld(1, MEM_LW, MTIME_MEM_ADDRESS_HIGH, 32'd0, "wrap_hi");
        ld(1, MEM_LW, MTIME_MEM_ADDRESS_LOW, 32'd3, "wrap_lo");

        // Compare: mtime restarts at 0, mtimecmp = {0, 20}.
        sw(1, MTIME_MEM_ADDRESS_LOW, 32'd0, "cmp_sw_mtime");
        sw(1, MTIMECMP_MEM_ADDRESS_HIGH, 32'd0, "cmp_sw_hi");
        sw(1, MTIMECMP_MEM_ADDRESS_LOW, 32'd20, "cmp_sw_lo");
        idle(18);
        chk_mtip1(1'b0, "cmp_before");
        chk_mtip1(1'b1, "cmp_rise");
        idle(3);
        chk_mtip1(1'b1, "cmp_hold");
        ld(1, MEM_LW, MTIMECMP_MEM_ADDRESS_LOW, 32'd20, "cmp_rd_lo");
        ld(1, MEM_LW, MTIMECMP_MEM_ADDRESS_HIGH, 32'd0, "cmp_rd_hi");
        sw(1, MTIMECMP_MEM_ADDRESS_HIGH, 32'd1, "cmp_raise");
        chk_mtip1(1'b1, "cmp_lag");
        chk_mtip1(1'b0, "cmp_clear");

        // Sub-word stores are rejected; narrow loads return the full word.
        expect_resp(1, 1'b1, '0, "sb_err");
        acc(1, MEM_SB, MTIMECMP_MEM_ADDRESS_LOW, 32'h0000_00AA, 1'b1, "sb_err");
        ld(1, MEM_LW, MTIMECMP_MEM_ADDRESS_LOW, 32'd20, "sb_keep");
        expect_resp(1, 1'b1, '0, "sh_err");
        acc(1, MEM_SH, MTIME_MEM_ADDRESS_HIGH, 32'h0000_BEEF, 1'b1, "sh_err");
        ld(1, MEM_LW, MTIME_MEM_ADDRESS_HIGH, 32'd0, "sh_keep");
        ld(1, MEM_LBU, MTIMECMP_MEM_ADDRESS_HIGH, 32'd1, "lbu_full");
        ld(1, MEM_LH, MTIMECMP_MEM_ADDRESS_LOW, 32'd20, "lh_full");

        // Misses and idle cycles.
        acc(1, MEM_LW, 32'h0000_8014, '0, 1'b0, "miss_lw");
        acc(1, MEM_SW, 32'h0000_8014, 32'hDEAD, 1'b0, "miss_sw");
        acc(1, MEM_NOP, MTIMECMP_MEM_ADDRESS_LOW, 32'd7, 1'b0, "nop_idle");
        ld(1, MEM_LW, MTIMECMP_MEM_ADDRESS_LOW, 32'd20, "miss_keep");

        // Reset while a load response is on the outputs.
        inst1 = MEM_LW; addr1 = MTIME_MEM_ADDRESS_LOW;
        @(posedge clk); #1;
        inst1 = MEM_NOP; addr1 = '0;
        rst_n = 1'b0;
        #1;
        check("midrst_rvalid", rvalid1, 0);
        check("midrst_rdata", rdata1, 0);
        @(posedge clk); #1; rst_n = 1'b1;
        ld(1, MEM_LW, MTIME_MEM_ADDRESS_LOW, 32'd0, "midrst_restart");
        ld(1, MEM_LW, MTIMECMP_MEM_ADDRESS_LOW, 32'hFFFF_FFFF, "midrst_cmp");
        idle(3);
        check("q1_drain", q1.size(), 0);

        // PRESCALE=4: one tick every 4 edges, unaffected by a mid-period write.
        @(posedge clk); #1; rst4_n = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            ld(4, MEM_LW, MTIME_MEM_ADDRESS_LOW, 32'((k - 1) / 4), $sformatf("p4_run%0d", k));
        end
        sw(4, MTIME_MEM_ADDRESS_LOW, 32'd100, "p4_sw");
        for (int k = 0; k < 7; k++) begin
            ld(4, MEM_LW, MTIME_MEM_ADDRESS_LOW, 32'(p4_exp[k]), $sformatf("p4_after%0d", k));
        end
        idle(3);
        check("q4_drain", q4.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mtimer_unit.md
# mtimer_unit

Memory-mapped RISC-V machine timer: a free-running 64-bit `mtime` counter and a 64-bit `mtimecmp` compare register, exposed as four 32-bit words on the data-memory port. It sits beside data memory behind the load/store path. It drives the machine timer interrupt level into the CSR unit, where the level becomes `mip.mtip` and, when enabled, traps with cause `M_TIMER_INT`.

## Interface
Parameters:
- `PRESCALE`, default 1: clock cycles per `mtime` tick. Legal values are ≥1.

Ports:
- `clk`, input, 1: single clock.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `mem_inst_i`, input, 4: `mem_inst_type_t` of the current access. `MEM_NOP` means idle.
- `addr_i`, input, 32: byte address of the access.
- `wdata_i`, input, 32: store data.
- `hit_o`, output, 1: combinational. High when `mem_inst_i` ≠ `MEM_NOP` and `addr_i` equals one of the four timer addresses.
- `rdata_o`, output, 32: registered load data.
- `rvalid_o`, output, 1: registered. Single-cycle pulse qualifying `rdata_o`.
- `err_o`, output, 1: registered. Single-cycle pulse on an unsupported access to a timer address.
- `mtip_o`, output, 1: registered timer interrupt level to the CSR unit.

## Operation
- **Decode.** Exact address compare against `MTIME_MEM_ADDRESS_LOW`/`HIGH` and `MTIMECMP_MEM_ADDRESS_LOW`/`HIGH`, mapped to `mtime_address_t`. Any other address gives `hit_o`=0 and no state change.
- **Stores.** Only `MEM_SW` writes. It replaces the addressed 32-bit half. `MEM_SB`/`MEM_SH` to a timer address change no state and pulse `err_o`.
- **Loads.** `MEM_LB`/`LH`/`LW`/`LBU`/`LHU` all return the full addressed 32-bit word. Width selection and extension belong to the load path.
- **Prescaler.** Counts 0..`PRESCALE`-1. `mtime` increments by 1 in the cycle the prescaler is at `PRESCALE`-1, and the prescaler then wraps to 0. With `PRESCALE`=1, `mtime` increments every cycle. Register writes never reset the prescaler.
- **mtime arithmetic.** 64-bit unsigned. 2^64-1 wraps to 0.
- **mtime write collisions.**
  - A write to `MTIME_LOW` in a tick cycle loads `wdata_i` into [31:0]. The high half holds its value and no carry is applied.
  - A write to `MTIME_HIGH` in a tick cycle loads [63:32]. The low half increments normally, and any carry into the high half is discarded.
- **mtimecmp.** Writes replace the addressed half. It does not count.
- **Compare.** `mtip_o` next = (`mtime` ≥ `mtimecmp`), 64-bit unsigned, evaluated on the register values after the current edge's updates. It is a level, not a pulse. It clears only when `mtimecmp` is raised above `mtime` or `mtime` is rewritten below it.

## Timing
- **Reset values (async, while `rst_n`=0):**
  - `mtime` = 0
  - `mtimecmp` = 64'hFFFF_FFFF_FFFF_FFFF
  - prescaler = 0
  - `mtip_o` = 0
  - `rdata_o` = 0
  - `rvalid_o` = 0
  - `err_o` = 0
- **Load latency.** Load hit at edge N: `rdata_o`/`rvalid_o` are valid for the cycle after edge N. `rdata_o` carries the register value before edge N's update. `rdata_o` holds its value when `rvalid_o`=0.
- **Store latency.** Store at edge N: the register holds the new value after edge N. `mtip_o` reflects it after edge N+1.
- **Compare latency.** `mtip_o` lags `mtime` crossing `mtimecmp` by exactly one cycle.
- **No stalls.** Every access completes in one cycle. At most one access per cycle.
- **Reset mid-operation.** A pending `rvalid_o`/`err_o` is dropped. The timer restarts from 0.
- **Reading 64-bit mtime.** There is no atomic snapshot. Software reads with the high/low/high retry loop.

## Structure
- **Package contents.** `riscV_unrn_pkg` supplies the timer addresses, `mtime_address_t`, `mem_inst_type_t` and `M_TIMER_INT`. Add `MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF` to the package.
- **Sub-module `mtimer_prescaler`.** Parameter `PRESCALE`, ports `clk`, `rst_n` and a `tick_o` pulse. When `PRESCALE`=1 it reduces to a constant 1.
- **Everything else.** Decode, registers, compare and read mux stay in `mtimer_unit`.

## Test plan
- **Reset.** Check every output and register against the reset list. With `PRESCALE`=1 and no access, a `MEM_LW` of `MTIME_LOW` issued 10 cycles after reset release returns 10 one cycle later with `rvalid_o`=1.
- **Compare.** Store `mtimecmp` = {0, 20}, with the high half written as 0 first. `mtip_o` rises exactly one cycle after `mtime` reaches 20 and stays high. Storing `MTIMECMP_HIGH` = 1 drops `mtip_o` after one cycle.
- **Wrap and carry.** `MEM_SW` `MTIME_HIGH` = FFFF_FFFF, then `MTIME_LOW` = FFFF_FFFE. Two ticks later `mtime` = 0. Low-to-high carry at FFFF_FFFF is verified separately.
- **Write collision.** With `PRESCALE`=1, `MEM_SW` `MTIME_LOW` = 5 in a tick cycle. The next read returns 5 (not 6), and the high half is unchanged.
- **Prescaler.** With `PRESCALE`=4, `mtime` advances by 1 every 4 cycles. A write mid-period does not shift the next tick.
- **Illegal and miss accesses.** `MEM_SB` to `MTIMECMP_LOW` leaves the value unchanged and pulses `err_o` once. `MEM_LW` to 0x8014 gives `hit_o`=0 with no `rvalid_o`.
